// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Successor of v in the ring 0..n-1.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after base, wrapping.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] hi_req;
    logic [N-1:0] pick;

    always_comb begin
        hi_req = '0;
        for (int i = 0; i < N; i++) begin
            hi_req[i] = req[i] && (i >= int'(base));
        end
        // Requests at or above base take precedence; otherwise wrap to the bottom.
        pick = (|hi_req) ? hi_req : req;
        idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) idx = IW'(i);
        end
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = pick[i] && (idx == IW'(i));
        end
        any = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_CH byte producers; a grant lasts a whole message.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    parameter  int MODE   = ARB_RR,
    localparam int IW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_wr,
    input  logic [N_CH*DATA_W-1:0]   ch_din,
    output logic [N_CH-1:0]          ch_grant,
    output logic [N_CH-1:0]          ch_ready,
    output logic                     uart_wr,
    output logic [DATA_W-1:0]        uart_din,
    input  logic                     uart_ready,
    output logic [IW-1:0]            grant_id,
    output logic                     busy,
    output logic [N_CH-1:0]          drop_err,
    input  logic                     err_clr
);

    arb_state_t      state_q, state_d;
    logic [N_CH-1:0] grant_q, grant_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic [IW-1:0]   last_q, last_d;
    logic [N_CH-1:0] drop_q, drop_d;

    logic [N_CH-1:0] pick_req;
    logic [IW-1:0]   pick_base;
    logic [N_CH-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            owner_active;

    rr_pick #(.N(N_CH)) u_pick (
        .req   (pick_req),
        .base  (pick_base),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        // The channel that just released may not win while we are draining it.
        pick_req  = (state_q == DRAIN) ? (ch_req & ~grant_q) : ch_req;
        pick_base = (MODE == ARB_FIXED) ? '0 : IW'(wrap_inc(int'(last_q), N_CH));
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_grant;
                    gid_d   = pick_idx;
                    last_d  = pick_idx;
                end
            end
            GRANT: begin
                if (!(|(ch_req & grant_q))) state_d = DRAIN;
            end
            DRAIN: begin
                if (uart_ready) begin
                    if (pick_any) begin
                        state_d = GRANT;
                        grant_d = pick_grant;
                        gid_d   = pick_idx;
                        last_d  = pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        owner_active = (state_q == GRANT);
        ch_ready     = owner_active ? (grant_q & {N_CH{uart_ready}}) : '0;
        uart_wr      = |(ch_wr & ch_ready);
        uart_din     = '0;
        if (owner_active) begin
            for (int i = 0; i < N_CH; i++) begin
                if (grant_q[i]) uart_din = ch_din[i*DATA_W +: DATA_W];
            end
        end
        // A strobe without permission is flagged; a new drop outranks err_clr.
        drop_d = (err_clr ? '0 : drop_q) | (ch_wr & ~ch_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            last_q  <= IW'(N_CH - 1);
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    assign ch_grant = grant_q;
    assign grant_id = gid_q;
    assign busy     = (state_q != IDLE);
    assign drop_err = drop_q;

endmodule
